// File: rtl/serial_sub.sv
// serial_sub: bit-serial 4-bit subtractor, one full-subtractor cell, start/done handshake
module serial_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff,
  output logic       borrow,
  output logic       ovf,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic       bw_q, bw_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic       d, bw_next, accept;
  // operand bits shift out LSB first; at cnt==3 bit 0 of each register holds the captured sign bit
  always_comb begin
    d        = a_q[0] ^ b_q[0] ^ bw_q;
    bw_next  = (~a_q[0] & b_q[0]) | (~a_q[0] & bw_q) | (b_q[0] & bw_q);
    accept   = start && state_q != RUN;
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    bw_d     = bw_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      bw_d    = 1'b0;
      cnt_d   = 2'd0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      bw_d  = bw_next;
      res_d = {d, res_q[3:1]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        diff_d   = {d, res_q[3:1]};
        borrow_d = bw_next;
        ovf_d    = (a_q[0] ^ b_q[0]) & (a_q[0] ^ d);
        state_d  = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bw_q     <= 1'b0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bw_q     <= bw_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
endmodule
